// File: rtl/writeback_stage_if.sv
// W-stage bundle: pipeline-register inputs, decode read ports, and status outputs.
// The master side is the pipeline/decode logic and the slave side is writeback_stage.
interface writeback_stage_if #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 64
);
   logic [3:0]        icode_w;
   logic              cnd_w;
   logic [3:0]        regA_w;
   logic [3:0]        regB_w;
   logic [DATA_W-1:0] valE_w;
   logic [DATA_W-1:0] valM_w;
   logic [2:0]        w_stat;
   logic [3:0]        srcA;
   logic [3:0]        srcB;
   logic [DATA_W-1:0] rvalA;
   logic [DATA_W-1:0] rvalB;
   logic [3:0]        dstE;
   logic [3:0]        dstM;
   logic [2:0]        proc_stat;
   logic              halted;
   logic [CNT_W-1:0]  retired;

   modport master (
      output icode_w, cnd_w, regA_w, regB_w, valE_w, valM_w, w_stat, srcA, srcB,
      input  rvalA, rvalB, dstE, dstM, proc_stat, halted, retired
   );

   modport slave (
      input  icode_w, cnd_w, regA_w, regB_w, valE_w, valM_w, w_stat, srcA, srcB,
      output rvalA, rvalB, dstE, dstM, proc_stat, halted, retired
   );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: owns the 15-entry register file, performs valE/valM
// writes, serves decode's two read ports, holds sticky status and a retire count.
// Optional macro REG_BYPASS_EN: read ports return same-cycle write data.
module writeback_stage #(
   parameter int                DATA_W    = 64,
   parameter int                CNT_W     = 64,
   parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
   input logic              clk,
   input logic              rst_n,
   writeback_stage_if.slave wb
);

   localparam logic [2:0] STAT_BUB = 3'd0;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [3:0] REG_RSP  = 4'h4;

   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   logic [DATA_W-1:0] regs_q [15];
   logic [DATA_W-1:0] regs_d [15];
   logic [2:0]        stat_q, stat_d;
   logic              halted_q, halted_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic [3:0]        dst_e, dst_m;
   logic [2:0]        stat_eff;
   logic              wr_en;
   logic [DATA_W-1:0] rval_a, rval_b;

   // Destination decode from the W-stage instruction fields
   always_comb begin
      dst_e = REG_NONE;
      dst_m = REG_NONE;
      case (wb.icode_w)
         I_RRMOVQ:                 dst_e = wb.cnd_w ? wb.regB_w : REG_NONE;
         I_IRMOVQ, I_OPQ:          dst_e = wb.regB_w;
         I_CALL, I_RET, I_PUSHQ:   dst_e = REG_RSP;
         I_POPQ: begin
            dst_e = REG_RSP;
            dst_m = wb.regA_w;
         end
         I_MRMOVQ:                 dst_m = wb.regA_w;
         default: begin
            dst_e = REG_NONE;
            dst_m = REG_NONE;
         end
      endcase
   end

   // Status normalisation (undefined codes behave as INS) and write enable
   always_comb begin
      stat_eff = (wb.w_stat > STAT_INS) ? STAT_INS : wb.w_stat;
      wr_en    = !halted_q && (stat_eff == STAT_AOK);
   end

   // Next-state: register writes (valM wins on collision), retire count, sticky status
   always_comb begin
      regs_d    = regs_q;
      stat_d    = stat_q;
      halted_d  = halted_q;
      retired_d = retired_q;
      if (wr_en) begin
         for (int unsigned i = 0; i < 15; i++) begin
            if (dst_m == 4'(i)) begin
               regs_d[i] = wb.valM_w;
            end else if (dst_e == 4'(i)) begin
               regs_d[i] = wb.valE_w;
            end
         end
         retired_d = retired_q + CNT_W'(1);
      end else if (!halted_q && (stat_eff != STAT_BUB)) begin
         stat_d   = stat_eff;
         halted_d = 1'b1;
         if (stat_eff == STAT_HLT) begin
            retired_d = retired_q + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 15; i++) begin
            regs_q[i] <= (i == 4) ? RSP_RESET : '0;
         end
         stat_q    <= STAT_AOK;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         regs_q    <= regs_d;
         stat_q    <= stat_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
      end
   end

   // Decode read ports; register 0xF always reads as zero
   always_comb begin
      rval_a = (wb.srcA == REG_NONE) ? '0 : regs_q[wb.srcA];
      rval_b = (wb.srcB == REG_NONE) ? '0 : regs_q[wb.srcB];
`ifdef REG_BYPASS_EN
      // Same-cycle bypass keeps the valM-over-valE priority of the write path
      if (wr_en && (wb.srcA != REG_NONE)) begin
         if (wb.srcA == dst_m) begin
            rval_a = wb.valM_w;
         end else if (wb.srcA == dst_e) begin
            rval_a = wb.valE_w;
         end
      end
      if (wr_en && (wb.srcB != REG_NONE)) begin
         if (wb.srcB == dst_m) begin
            rval_b = wb.valM_w;
         end else if (wb.srcB == dst_e) begin
            rval_b = wb.valE_w;
         end
      end
`endif
   end

   assign wb.rvalA     = rval_a;
   assign wb.rvalB     = rval_b;
   assign wb.dstE      = dst_e;
   assign wb.dstM      = dst_m;
   assign wb.proc_stat = stat_q;
   assign wb.halted    = halted_q;
   assign wb.retired   = retired_q;

endmodule
